// File: rtl/uart_frame_parser.sv
// uart_frame_parser: drains the UART RX FIFO, parses SOF/LEN/PAYLOAD/CHK
// frames, streams payload bytes over valid/ready and reports per-frame status.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int                 N_BIT       = 8,
  parameter logic [N_BIT-1:0]   SOF_BYTE    = N_BIT'(8'hA5),
  parameter int                 MAX_LEN     = 16,
  parameter int                 TIMEOUT_CYC = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_empty,
  input  logic [N_BIT-1:0] rx_rd_data,
  input  logic             rx_parity_error,
  input  logic             rx_frame_error,
  output logic             rx_rd_en,
  output logic [N_BIT-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             pkt_done,
  output logic [2:0]       pkt_err
);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_LEN  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_CHK  = 2'd3;

  localparam logic [N_BIT-1:0] MAX_LEN_V = N_BIT'(MAX_LEN);
  localparam logic [N_BIT-1:0] ONE_V     = N_BIT'(1);

  localparam logic [2:0] E_OK   = 3'd0;
  localparam logic [2:0] E_CHK  = 3'd1;
  localparam logic [2:0] E_LINE = 3'd2;
  localparam logic [2:0] E_LEN  = 3'd3;
  localparam logic [2:0] E_TMO  = 3'd4;

  // Elaboration guards: LEN must fit in a byte and the timeout compare needs >= 2.
  if (MAX_LEN < 1 || MAX_LEN >= (1 << N_BIT)) begin : g_bad_max_len
    $error("MAX_LEN out of range for N_BIT");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  logic [1:0]       state;
  logic [N_BIT-1:0] acc;
  logic [N_BIT-1:0] cnt;
  logic             rd_pend;   // a pop was issued last cycle; its byte is on rx_rd_data now
  logic             strobe;
  logic             line_err;
  logic             out_free;
  logic             tmo;

  assign strobe   = rd_pend;
  assign line_err = rx_parity_error | rx_frame_error;
  // The output register must be able to take whatever byte the pop returns.
  assign out_free = !out_valid || out_ready;
  assign rx_rd_en = !rst && !rx_empty && !rd_pend && out_free;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_HIT = TMO_W'(TIMEOUT_CYC - 2);

  logic [TMO_W-1:0] tmo_cnt;
  logic             stall;

  assign stall = out_valid && !out_ready;
  // tmo_cnt is (cycles since last strobe - 1); pkt_done is registered, so
  // firing at TIMEOUT_CYC-2 puts the pulse exactly TIMEOUT_CYC cycles after the strobe.
  assign tmo = (state != S_HUNT) && !strobe && !stall && (tmo_cnt == TMO_HIT);

  // Inter-byte idle counter; consumer backpressure is not the sender's fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  tmo_cnt <= '0;
    else if (strobe || stall || state == S_HUNT) tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // Frame parser: fetch tracking, state walk, checksum, output register and status pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HUNT;
      acc       <= '0;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= E_OK;
    end else begin
      rd_pend  <= rx_rd_en;
      pkt_done <= 1'b0;
      pkt_err  <= E_OK;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (strobe) begin
        if (line_err) begin
          // Corrupted bytes while hunting are just noise; mid-frame they kill the frame.
          if (state != S_HUNT) begin
            pkt_done <= 1'b1;
            pkt_err  <= E_LINE;
            state    <= S_HUNT;
          end
        end else begin
          case (state)
            S_HUNT: begin
              if (rx_rd_data == SOF_BYTE) begin
                acc   <= '0;
                state <= S_LEN;
              end
            end
            S_LEN: begin
              if (rx_rd_data == '0 || rx_rd_data > MAX_LEN_V) begin
                pkt_done <= 1'b1;
                pkt_err  <= E_LEN;
                state    <= S_HUNT;
              end else begin
                acc   <= rx_rd_data;
                cnt   <= rx_rd_data;
                state <= S_PAY;
              end
            end
            S_PAY: begin
              out_data  <= rx_rd_data;
              out_valid <= 1'b1;
              out_last  <= (cnt == ONE_V);
              acc       <= acc + rx_rd_data;
              cnt       <= cnt - ONE_V;
              if (cnt == ONE_V) state <= S_CHK;
            end
            S_CHK: begin
              pkt_done <= 1'b1;
              pkt_err  <= (rx_rd_data == acc) ? E_OK : E_CHK;
              state    <= S_HUNT;
            end
            default: state <= S_HUNT;
          endcase
        end
      end else if (tmo) begin
        pkt_done <= 1'b1;
        pkt_err  <= E_TMO;
        state    <= S_HUNT;
      end
    end
  end

endmodule
